gci_std_display_vram_write_port: RTL and testbench

GCI_STD_DISPLAY_VRAM_WRITE_PORT -- requirements
Module: gci_std_display_vram_write_port

---
 rtl/gci_std_display_parameter.sv | 28 ++
 rtl/gci_std_display_sync_fifo.sv | 69 ++++++
 rtl/gci_std_display_vram_write_port.sv | 125 ++++++++++++
 tb/tb_gci_std_display_vram_write_port.sv | 387 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gci_std_display_parameter.sv
// ---------------------------------------------------------------------------
// gci_std_display_parameter
// Shared display parameter package: default sizes for the VRAM write port and
// the state encoding of its arbitration/write FSM.
// ---------------------------------------------------------------------------
package gci_std_display_parameter;

  localparam int P_DEF_MEM_ADDR_N  = 19;  // VRAM word-address width
  localparam int P_DEF_FIFO_DEPTH  = 16;  // write FIFO entries (power of two)
  localparam int P_DEF_BURST_MAX   = 8;   // writes per arbitration grant

  localparam int P_WR_ADDR_N = 19;        // pixel address width from upstream
  localparam int P_WR_DATA_N = 16;        // pixel data width from upstream

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_REQ    = 2'd1,
    ST_WRITE  = 2'd2,
    ST_FINISH = 2'd3
  } vram_wr_state_t;

  // One queued pixel write: address in the upper bits, data in the lower.
  typedef struct packed {
    logic [P_WR_ADDR_N-1:0] addr;
    logic [P_WR_DATA_N-1:0] data;
  } vram_wr_entry_t;

endpackage

// File: rtl/gci_std_display_sync_fifo.sv
// ---------------------------------------------------------------------------
// gci_std_display_sync_fifo
// Single-clock first-word-fall-through FIFO.
//   iCLOCK / inRESET : clock, synchronous active-low reset
//   iPUSH / iDATA    : write strobe and data (ignored while full)
//   iPOP             : drop the head entry (ignored while empty)
//   oDATA            : current head entry, valid whenever !oEMPTY
//   oFULL / oEMPTY   : decoded from the registered count
//   oCOUNT           : number of stored entries, 0..P_DEPTH
// ---------------------------------------------------------------------------
module gci_std_display_sync_fifo #(
  parameter int P_N     = 35,
  parameter int P_DEPTH = 16
) (
  input  logic                       iCLOCK,
  input  logic                       inRESET,
  input  logic                       iPUSH,
  input  logic [P_N-1:0]             iDATA,
  input  logic                       iPOP,
  output logic [P_N-1:0]             oDATA,
  output logic                       oFULL,
  output logic                       oEMPTY,
  output logic [$clog2(P_DEPTH):0]   oCOUNT
);

  localparam int PTR_W = $clog2(P_DEPTH);

  logic [P_N-1:0]   mem_reg [P_DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [PTR_W:0]   count_reg;
  logic             push_ok;
  logic             pop_ok;

  assign oFULL   = (count_reg == (PTR_W+1)'(P_DEPTH));
  assign oEMPTY  = (count_reg == '0);
  assign oCOUNT  = count_reg;
  assign push_ok = iPUSH && !oFULL;
  assign pop_ok  = iPOP && !oEMPTY;

  // The head must be visible in the same cycle the write port strobes the
  // VRAM, so the read side is asynchronous (distributed memory).
  assign oDATA = mem_reg[rd_ptr_reg];

  // Storage carries no reset; the pointers alone define valid contents.
  always_ff @(posedge iCLOCK) begin
    if (push_ok) begin
      mem_reg[wr_ptr_reg] <= iDATA;
    end
  end

  // Power-of-two depth: pointers wrap by natural overflow.
  always_ff @(posedge iCLOCK) begin
    if (!inRESET) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push_ok) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/gci_std_display_vram_write_port.sv
// ---------------------------------------------------------------------------
// gci_std_display_vram_write_port
// Buffers pixel writes in a FIFO and drains them to VRAM in bursts of at most
// P_BURST_MAX writes per bus grant.
//   iCLOCK / inRESET          : clock, synchronous active-low reset
//   iWR_REQ/iWR_ADDR/iWR_DATA : pixel write command; oWR_FULL refuses it
//   oVRAM_ARBIT_REQ / _ACK    : bus request and grant
//   oVRAM_ARBIT_FINISH        : one-cycle bus release pulse
//   oVRAM_ENA/_RW/_ADDR/_DATA : VRAM write strobe and payload; iVRAM_BUSY stalls
//   oIDLE                     : FIFO empty and FSM idle
// ---------------------------------------------------------------------------
module gci_std_display_vram_write_port
  import gci_std_display_parameter::*;
#(
  parameter int P_MEM_ADDR_N = P_DEF_MEM_ADDR_N,
  parameter int P_FIFO_DEPTH = P_DEF_FIFO_DEPTH,
  parameter int P_BURST_MAX  = P_DEF_BURST_MAX
) (
  input  logic                    iCLOCK,
  input  logic                    inRESET,
  input  logic                    iWR_REQ,
  input  logic [P_WR_ADDR_N-1:0]  iWR_ADDR,
  input  logic [P_WR_DATA_N-1:0]  iWR_DATA,
  output logic                    oWR_FULL,
  output logic                    oVRAM_ARBIT_REQ,
  input  logic                    iVRAM_ARBIT_ACK,
  output logic                    oVRAM_ARBIT_FINISH,
  output logic                    oVRAM_ENA,
  input  logic                    iVRAM_BUSY,
  output logic                    oVRAM_RW,
  output logic [P_MEM_ADDR_N-1:0] oVRAM_ADDR,
  output logic [31:0]             oVRAM_DATA,
  output logic                    oIDLE
);

  localparam int CNT_W   = $clog2(P_FIFO_DEPTH) + 1;
  localparam int BURST_W = $clog2(P_BURST_MAX + 1);

  vram_wr_state_t      state_reg, state_next;
  logic [BURST_W-1:0]  burst_reg, burst_next;
  vram_wr_entry_t      push_entry, head_entry;
  logic                fifo_full, fifo_empty;
  logic [CNT_W-1:0]    fifo_count;
  logic                fifo_push;
  logic                write_ena;
  logic                arb_req, arb_finish;

  assign push_entry = '{addr: iWR_ADDR, data: iWR_DATA};
  assign fifo_push  = iWR_REQ && !fifo_full;
  assign write_ena  = (state_reg == ST_WRITE) && !fifo_empty && !iVRAM_BUSY;

  gci_std_display_sync_fifo #(
    .P_N     ($bits(vram_wr_entry_t)),
    .P_DEPTH (P_FIFO_DEPTH)
  ) u_fifo (
    .iCLOCK  (iCLOCK),
    .inRESET (inRESET),
    .iPUSH   (fifo_push),
    .iDATA   (push_entry),
    .iPOP    (write_ena),
    .oDATA   (head_entry),
    .oFULL   (fifo_full),
    .oEMPTY  (fifo_empty),
    .oCOUNT  (fifo_count)
  );

  always_ff @(posedge iCLOCK) begin
    if (!inRESET) begin
      state_reg <= ST_IDLE;
      burst_reg <= '0;
    end else begin
      state_reg <= state_next;
      burst_reg <= burst_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    burst_next = burst_reg;
    arb_req    = 1'b0;
    arb_finish = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (!fifo_empty) state_next = ST_REQ;
      end
      ST_REQ: begin
        arb_req = 1'b1;
        if (iVRAM_ARBIT_ACK) begin
          state_next = ST_WRITE;
          burst_next = '0;
        end
      end
      ST_WRITE: begin
        if (write_ena) begin
          burst_next = burst_reg + 1'b1;
          // Release the bus on the write that fills the burst, or on the
          // write that leaves the FIFO empty so the grant is not held idle.
          if ((burst_reg == BURST_W'(P_BURST_MAX - 1)) ||
              ((fifo_count == CNT_W'(1)) && !fifo_push)) begin
            state_next = ST_FINISH;
          end
        end else if (fifo_empty) begin
          state_next = ST_FINISH;
        end
      end
      ST_FINISH: begin
        arb_finish = 1'b1;
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Outputs are forced to their reset values while inRESET is low, so the
  // bus sees a clean release even in the cycle reset is first applied.
  assign oWR_FULL           = inRESET && fifo_full;
  assign oVRAM_ARBIT_REQ    = inRESET && arb_req;
  assign oVRAM_ARBIT_FINISH = inRESET && arb_finish;
  assign oVRAM_ENA          = inRESET && write_ena;
  assign oVRAM_RW           = oVRAM_ENA;
  assign oVRAM_ADDR         = oVRAM_ENA ? P_MEM_ADDR_N'(head_entry.addr) : '0;
  assign oVRAM_DATA         = oVRAM_ENA ? {16'h0000, head_entry.data} : 32'h0;
  assign oIDLE              = !inRESET || (fifo_empty && (state_reg == ST_IDLE));

endmodule

// File: tb/tb_gci_std_display_vram_write_port.sv
module tb_gci_std_display_vram_write_port;

  logic        iCLOCK = 1'b0;
  logic        inRESET;
  logic        iWR_REQ;
  logic [18:0] iWR_ADDR;
  logic [15:0] iWR_DATA;
  logic        oWR_FULL;
  logic        oVRAM_ARBIT_REQ;
  logic        iVRAM_ARBIT_ACK;
  logic        oVRAM_ARBIT_FINISH;
  logic        oVRAM_ENA;
  logic        iVRAM_BUSY;
  logic        oVRAM_RW;
  logic [18:0] oVRAM_ADDR;
  logic [31:0] oVRAM_DATA;
  logic        oIDLE;

  always #5 iCLOCK = ~iCLOCK;

  gci_std_display_vram_write_port dut (
    .iCLOCK             (iCLOCK),
    .inRESET            (inRESET),
    .iWR_REQ            (iWR_REQ),
    .iWR_ADDR           (iWR_ADDR),
    .iWR_DATA           (iWR_DATA),
    .oWR_FULL           (oWR_FULL),
    .oVRAM_ARBIT_REQ    (oVRAM_ARBIT_REQ),
    .iVRAM_ARBIT_ACK    (iVRAM_ARBIT_ACK),
    .oVRAM_ARBIT_FINISH (oVRAM_ARBIT_FINISH),
    .oVRAM_ENA          (oVRAM_ENA),
    .iVRAM_BUSY         (iVRAM_BUSY),
    .oVRAM_RW           (oVRAM_RW),
    .oVRAM_ADDR         (oVRAM_ADDR),
    .oVRAM_DATA         (oVRAM_DATA),
    .oIDLE              (oIDLE)
  );

  typedef struct packed {
    logic [18:0] a;
    logic [15:0] d;
  } ent_t;

  int   errors = 0;
  int   checks = 0;
  ent_t sb[$];          // expected VRAM writes, in order
  int   model_count = 0;
  int   writes_cnt = 0;
  int   last_burst = -1;

  // Scoreboard: accepted pushes enter the queue, every VRAM strobe pops and
  // compares. The model FIFO occupancy also predicts oWR_FULL.
  always @(negedge iCLOCK) begin
    ent_t e;
    bit   model_full;
    if (inRESET !== 1'b1) begin
      sb.delete();
      model_count = 0;
      writes_cnt  = 0;
    end else begin
      model_full = (model_count == 16);
      checks++;
      if (oWR_FULL !== model_full) begin
        errors++;
        $display("FAIL full_flag t=%0t actual=%b required=%b", $time, oWR_FULL, model_full);
      end
      if (oVRAM_ENA === 1'b1) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_write t=%0t addr=%h", $time, oVRAM_ADDR);
        end else begin
          e = sb.pop_front();
          if (oVRAM_ADDR !== e.a || oVRAM_DATA !== {16'h0000, e.d} || oVRAM_RW !== 1'b1) begin
            errors++;
            $display("FAIL write_payload t=%0t actual=%h/%h/%b required=%h/%h/1",
                     $time, oVRAM_ADDR, oVRAM_DATA, oVRAM_RW, e.a, {16'h0000, e.d});
          end else begin
            $display("write addr=%h data=%h", oVRAM_ADDR, oVRAM_DATA);
          end
          model_count--;
        end
        writes_cnt++;
      end else begin
        checks++;
        if (oVRAM_ADDR !== '0 || oVRAM_DATA !== '0 || oVRAM_RW !== 1'b0) begin
          errors++;
          $display("FAIL idle_bus t=%0t actual=%h/%h/%b required=0/0/0",
                   $time, oVRAM_ADDR, oVRAM_DATA, oVRAM_RW);
        end
      end
      if (iWR_REQ && !model_full) begin
        sb.push_back('{a: iWR_ADDR, d: iWR_DATA});
        model_count++;
      end
      if (oVRAM_ARBIT_FINISH === 1'b1) begin
        last_burst = writes_cnt;
        writes_cnt = 0;
      end
    end
  end

  task automatic step();
    @(posedge iCLOCK);
    #1;
  endtask

  task automatic test_reset();
    repeat (2) step();
    @(negedge iCLOCK);
    checks++;
    if ({oWR_FULL, oVRAM_ARBIT_REQ, oVRAM_ARBIT_FINISH, oVRAM_ENA, oVRAM_RW} !== 5'b0) begin
      errors++;
      $display("FAIL reset_ctrl actual=%b required=00000",
               {oWR_FULL, oVRAM_ARBIT_REQ, oVRAM_ARBIT_FINISH, oVRAM_ENA, oVRAM_RW});
    end
    checks++;
    if (oVRAM_ADDR !== '0 || oVRAM_DATA !== '0) begin
      errors++;
      $display("FAIL reset_bus actual=%h/%h required=0/0", oVRAM_ADDR, oVRAM_DATA);
    end
    checks++;
    if (oIDLE !== 1'b1) begin
      errors++;
      $display("FAIL reset_idle actual=%b required=1", oIDLE);
    end
    step();
    inRESET = 1'b1;
    $display("test_reset done");
  endtask

  task automatic test_single();
    iVRAM_ARBIT_ACK = 1'b1;
    step();
    iWR_REQ = 1'b1; iWR_ADDR = 19'h12345; iWR_DATA = 16'hBEEF;   // cycle 0
    @(negedge iCLOCK);
    checks++;
    if (oVRAM_ARBIT_REQ !== 1'b0 || oIDLE !== 1'b1) begin
      errors++;
      $display("FAIL single_c0 actual=req%b idle%b required=req0 idle1", oVRAM_ARBIT_REQ, oIDLE);
    end
    step();
    iWR_REQ = 1'b0;                                               // cycle 1
    @(negedge iCLOCK);
    checks++;
    if (oVRAM_ARBIT_REQ !== 1'b0 || oIDLE !== 1'b0) begin
      errors++;
      $display("FAIL single_c1 actual=req%b idle%b required=req0 idle0", oVRAM_ARBIT_REQ, oIDLE);
    end
    step(); @(negedge iCLOCK);                                    // cycle 2
    checks++;
    if (oVRAM_ARBIT_REQ !== 1'b1 || oVRAM_ENA !== 1'b0) begin
      errors++;
      $display("FAIL single_c2 actual=req%b ena%b required=req1 ena0", oVRAM_ARBIT_REQ, oVRAM_ENA);
    end
    step(); @(negedge iCLOCK);                                    // cycle 3
    checks++;
    if (oVRAM_ENA !== 1'b1 || oVRAM_ADDR !== 19'h12345 || oVRAM_DATA !== 32'h0000BEEF
        || oVRAM_ARBIT_REQ !== 1'b0) begin
      errors++;
      $display("FAIL single_c3 actual=ena%b %h %h req%b required=ena1 12345 0000beef req0",
               oVRAM_ENA, oVRAM_ADDR, oVRAM_DATA, oVRAM_ARBIT_REQ);
    end
    step(); @(negedge iCLOCK);                                    // cycle 4
    checks++;
    if (oVRAM_ARBIT_FINISH !== 1'b1 || oVRAM_ENA !== 1'b0) begin
      errors++;
      $display("FAIL single_c4 actual=fin%b ena%b required=fin1 ena0", oVRAM_ARBIT_FINISH, oVRAM_ENA);
    end
    step(); @(negedge iCLOCK);                                    // cycle 5
    checks++;
    if (oIDLE !== 1'b1 || oVRAM_ARBIT_FINISH !== 1'b0) begin
      errors++;
      $display("FAIL single_c5 actual=idle%b fin%b required=idle1 fin0", oIDLE, oVRAM_ARBIT_FINISH);
    end
    // A grant while idle must not start anything.
    repeat (3) step();
    @(negedge iCLOCK);
    checks++;
    if (oIDLE !== 1'b1 || oVRAM_ARBIT_REQ !== 1'b0 || oVRAM_ENA !== 1'b0) begin
      errors++;
      $display("FAIL ack_ignored actual=idle%b req%b ena%b required=idle1 req0 ena0",
               oIDLE, oVRAM_ARBIT_REQ, oVRAM_ENA);
    end
    iVRAM_ARBIT_ACK = 1'b0;
    $display("test_single done");
  endtask

  task automatic test_burst();
    int bursts[2] = '{8, 4};
    for (int i = 0; i < 12; i++) begin
      step();
      iWR_REQ = 1'b1; iWR_ADDR = 19'h00100 + 19'(i); iWR_DATA = 16'hA000 + 16'(i);
    end
    step();
    iWR_REQ = 1'b0;
    iVRAM_ARBIT_ACK = 1'b1;
    for (int g = 0; g < 2; g++) begin
      bit found = 0;
      for (int c = 0; c < 40 && !found; c++) begin
        step(); @(negedge iCLOCK);
        if (oVRAM_ARBIT_FINISH === 1'b1) found = 1;
      end
      step();
      checks++;
      if (!found || last_burst != bursts[g]) begin
        errors++;
        $display("FAIL burst_len grant=%0d actual=%0d found=%0d required=%0d",
                 g, last_burst, found, bursts[g]);
      end else begin
        $display("burst grant=%0d writes=%0d", g, last_burst);
      end
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL burst_drain actual=%0d pending required=0", sb.size());
    end
    iVRAM_ARBIT_ACK = 1'b0;
  endtask

  task automatic test_full();
    bit found = 0;
    for (int i = 0; i < 17; i++) begin
      step();
      iWR_REQ = 1'b1; iWR_ADDR = 19'h00200 + 19'(i); iWR_DATA = 16'hC000 + 16'(i);
      @(negedge iCLOCK);
      checks++;
      if (oWR_FULL !== (i == 16)) begin
        errors++;
        $display("FAIL full_push%0d actual=%b required=%b", i, oWR_FULL, (i == 16));
      end
    end
    step();
    iWR_REQ = 1'b0;
    @(negedge iCLOCK);
    checks++;
    if (oWR_FULL !== 1'b1) begin
      errors++;
      $display("FAIL full_hold actual=%b required=1", oWR_FULL);
    end
    // Keep pushing while the full FIFO drains: simultaneous push/pop.
    iVRAM_ARBIT_ACK = 1'b1;
    for (int j = 0; j < 8; j++) begin
      step();
      iWR_REQ = 1'b1; iWR_ADDR = 19'h00300 + 19'(j); iWR_DATA = 16'hD000 + 16'(j);
    end
    step();
    iWR_REQ = 1'b0;
    for (int c = 0; c < 150 && !found; c++) begin
      step(); @(negedge iCLOCK);
      if (oIDLE === 1'b1) found = 1;
    end
    checks++;
    if (!found || sb.size() != 0) begin
      errors++;
      $display("FAIL full_drain actual=found%0d pending%0d required=found1 pending0", found, sb.size());
    end
    iVRAM_ARBIT_ACK = 1'b0;
    $display("test_full done");
  endtask

  task automatic test_busy();
    bit   found = 0;
    ent_t head;
    for (int i = 0; i < 4; i++) begin
      step();
      iWR_REQ = 1'b1; iWR_ADDR = 19'h00400 + 19'(i); iWR_DATA = 16'hE000 + 16'(i);
    end
    step();
    iWR_REQ = 1'b0;
    iVRAM_ARBIT_ACK = 1'b1;
    for (int c = 0; c < 20 && !found; c++) begin
      @(negedge iCLOCK);
      if (oVRAM_ENA === 1'b1) found = 1;
      else step();
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL busy_start actual=no_write required=write");
    end
    step();
    iVRAM_BUSY = 1'b1;
    head = (sb.size() != 0) ? sb[0] : '0;
    for (int k = 0; k < 3; k++) begin
      @(negedge iCLOCK);
      checks++;
      if (oVRAM_ENA !== 1'b0) begin
        errors++;
        $display("FAIL busy_stall%0d actual=%b required=0", k, oVRAM_ENA);
      end
      step();
    end
    iVRAM_BUSY = 1'b0;
    @(negedge iCLOCK);
    checks++;
    if (oVRAM_ENA !== 1'b1 || oVRAM_ADDR !== head.a) begin
      errors++;
      $display("FAIL busy_resume actual=ena%b %h required=ena1 %h", oVRAM_ENA, oVRAM_ADDR, head.a);
    end
    found = 0;
    for (int c = 0; c < 30 && !found; c++) begin
      step(); @(negedge iCLOCK);
      if (oIDLE === 1'b1) found = 1;
    end
    checks++;
    if (!found || sb.size() != 0) begin
      errors++;
      $display("FAIL busy_drain actual=found%0d pending%0d required=found1 pending0", found, sb.size());
    end
    iVRAM_ARBIT_ACK = 1'b0;
    $display("test_busy done");
  endtask

  task automatic test_reset_write();
    bit found = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      iWR_REQ = 1'b1; iWR_ADDR = 19'h00500 + 19'(i); iWR_DATA = 16'hF000 + 16'(i);
    end
    step();
    iWR_REQ = 1'b0;
    iVRAM_ARBIT_ACK = 1'b1;
    for (int c = 0; c < 20 && !found; c++) begin
      @(negedge iCLOCK);
      if (oVRAM_ENA === 1'b1) found = 1;
      else step();
    end
    step();            // five entries remain queued, FSM in WRITE
    inRESET = 1'b0;
    @(negedge iCLOCK);
    checks++;
    if (!found || {oWR_FULL, oVRAM_ARBIT_REQ, oVRAM_ARBIT_FINISH, oVRAM_ENA, oVRAM_RW} !== 5'b0
        || oVRAM_ADDR !== '0 || oVRAM_DATA !== '0 || oIDLE !== 1'b1) begin
      errors++;
      $display("FAIL rst_write actual=found%0d ctl%b %h %h idle%b required=found1 ctl00000 0 0 idle1",
               found, {oWR_FULL, oVRAM_ARBIT_REQ, oVRAM_ARBIT_FINISH, oVRAM_ENA, oVRAM_RW},
               oVRAM_ADDR, oVRAM_DATA, oIDLE);
    end
    step();
    inRESET = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge iCLOCK);
      checks++;
      if (oVRAM_ENA !== 1'b0 || oIDLE !== 1'b1 || oVRAM_ARBIT_REQ !== 1'b0 || oVRAM_ARBIT_FINISH !== 1'b0) begin
        errors++;
        $display("FAIL rst_after%0d actual=ena%b idle%b req%b fin%b required=ena0 idle1 req0 fin0",
                 k, oVRAM_ENA, oIDLE, oVRAM_ARBIT_REQ, oVRAM_ARBIT_FINISH);
      end
      step();
    end
    iWR_REQ = 1'b1; iWR_ADDR = 19'h00600; iWR_DATA = 16'h1234;
    step();
    iWR_REQ = 1'b0;
    found = 0;
    for (int c = 0; c < 20 && !found; c++) begin
      step(); @(negedge iCLOCK);
      if (oIDLE === 1'b1) found = 1;
    end
    checks++;
    if (!found || sb.size() != 0) begin
      errors++;
      $display("FAIL rst_newpush actual=found%0d pending%0d required=found1 pending0", found, sb.size());
    end
    iVRAM_ARBIT_ACK = 1'b0;
    $display("test_reset_write done");
  endtask

  initial begin
    inRESET = 1'b0;
    iWR_REQ = 1'b0;
    iWR_ADDR = '0;
    iWR_DATA = '0;
    iVRAM_ARBIT_ACK = 1'b0;
    iVRAM_BUSY = 1'b0;
    test_reset();
    test_single();
    test_burst();
    test_full();
    test_busy();
    test_reset_write();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
